il1_ahb_refill: RTL
===================

// Module: il1_ahb_refill
// PURPOSE
// - IL1 miss refill engine between IL1 miss controller and AHB-Lite bus.
// - On refill_req, fetches missing 8-word line via one WRAP8 burst starting at critical word.
// - Streams each beat into IL1 data array; returns critical instruction to controller.
// - Holds update high for the whole refill.
// PARAMETERS
// - PC_LENGTH       32  width of miss PC / HADDR
// - INST_LENGTH     32  instruction / HRDATA width
// - LINE_WORDS      8   words per IL1 line; fixed to 8 (WRAP8), elaboration error otherwise
// PORTS
// - hclk         in   1                      clock, posedge; same source as cache_clk
// - rst_n        in   1                      reset, asynchronous, active-low
// - refill_req   in   1                      one-cycle start pulse (controller update_trigger)
// - refill_addr  in   PC_LENGTH              miss PC (controller pc_up), sampled with refill_req
// - update       out  1                      refill in progress; critical word valid
// - update_inst  out  INST_LENGTH            critical instruction (word at refill_addr)
// - busy         out  1                      FSM not IDLE
// - wr_en        out  1                      write one word into IL1 line buffer
// - wr_word      out  $clog2(LINE_WORDS)     word index of wr_data
// - wr_data      out  INST_LENGTH            beat data
// - line_done    out  1                      pulse: all 8 words written OK
// - refill_err   out  1                      pulse: burst aborted on HRESP=ERROR
// - haddr        out  PC_LENGTH              AHB address
// - htrans       out  2                      IDLE/NONSEQ/SEQ
// - hburst       out  3                      constant WRAP8 (3'b100)
// - hsize        out  3                      constant word (3'b010)
// - hwrite       out  1                      constant 0
// - hready       in   1                      AHB ready
// - hresp        in   1                      0 OKAY, 1 ERROR
// - hrdata       in   INST_LENGTH            AHB read data
// BEHAVIOUR
// - Reset: FSM=IDLE, htrans=IDLE, haddr=0, all other outputs/counters/update_inst=0.
// - Reset mid-burst aborts immediately; no line_done.
// - FSM states: IDLE, ADDR, STREAM, DONE.
//   - IDLE: refill_req -> latch refill_addr, go ADDR. refill_req outside IDLE is ignored.
//   - ADDR: htrans=NONSEQ, haddr=base. On hready -> STREAM, addr_cnt=1.
//   - STREAM: address phase of beat addr_cnt overlaps data phase of beat data_cnt (AHB pipelining).
//     - htrans=SEQ while addr_cnt<8, IDLE after.
//     - Counters advance only when hready=1.
//   - DONE: one cycle; update=0, line_done=1 -> IDLE.
// - Beat address: {addr[PC-1:5], (addr[4:2]+n)[2:0], 2'b00}; word index wraps mod 8 (WRAP8).
// - Data beat accepted when hready=1 && hresp=0 in data phase:
//   - wr_en=1, wr_word=(addr[4:2]+data_cnt) mod 8, wr_data=hrdata, same cycle (combinational from bus).
// - Beat 0 (critical word): update_inst<=hrdata, update<=1 next edge.
//   - update stays 1 until last beat accepted; deasserts entering DONE.
//   - Controller sees update rise, halts release, then fall.
// - hready=0: all outputs stable, no wr_en.
// - hresp=1 (first ERROR cycle, hready=0):
//   - drive htrans=IDLE next cycle (cancel).
//   - pulse refill_err, clear update, go IDLE; no line_done.
//   - Words already written are invalid; IL1 must not set line valid.
// - update_inst held until next refill beat 0; update=0 during ADDR.
// - busy=1 in ADDR/STREAM/DONE.
// - Latency (zero-wait slave): refill_req@T0 -> NONSEQ@T1 -> beat0 data@T2, update=1@T3 -> last beat@T9 -> DONE/line_done@T10.
// STRUCTURE
// - renas_package additions:
//   - htrans_t enum {HTRANS_IDLE=2'b00, HTRANS_NONSEQ=2'b10, HTRANS_SEQ=2'b11}
//   - HBURST_WRAP8, HSIZE_WORD, HRESP_OKAY/ERROR constants
//   - refill_state_t enum.
// - LINE_WORDS shared with IL1 via renas_user_parameters.
// - No sub-module; wrap-address generation is one inline function (wrap_word_idx) in renas_package, reused by DL1 refill.
// TESTING
// - Zero-wait: refill_addr=0x0000_1014 -> haddr 0x14,0x18,0x1C,0x00,0x04,0x08,0x0C,0x10 (upper 0x1000);
//   - wr_word 5,6,7,0..4; update_inst=beat0; line_done@T10.
// - Wait states: hready=0 2 cycles on beat 3 -> haddr/htrans frozen, no wr_en, line_done 2 cycles later.
// - Aligned addr 0x2000: wr_word 0..7 in order; hburst=3'b100, hsize=3'b010, hwrite=0 throughout.
// - ERROR on beat 4 -> htrans=IDLE next cycle, refill_err pulse, update=0, line_done never, busy=0.
// - refill_req pulsed during STREAM -> ignored, haddr sequence unchanged.
// - rst_n low mid-STREAM -> htrans=IDLE, update=0, busy=0 asynchronously; new refill_req after release completes normally.

Source files
------------

// File: rtl/il1_ahb_refill_pkg.sv
// Shared types and constants for the IL1 refill engine and its AHB-Lite master port.
// The wrap-index helper is also used by the DL1 refill path.
package il1_ahb_refill_pkg;

    localparam int IL1_LINE_WORDS = 8;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    localparam logic [2:0] HBURST_WRAP8 = 3'b100;
    localparam logic [2:0] HSIZE_WORD   = 3'b010;
    localparam logic       HRESP_OKAY   = 1'b0;
    localparam logic       HRESP_ERROR  = 1'b1;

    typedef enum logic [1:0] {
        RF_IDLE,
        RF_ADDR,
        RF_STREAM,
        RF_DONE
    } refill_state_t;

    // Word index of beat n of a WRAP8 burst starting at start_idx (wraps mod 8).
    function automatic logic [2:0] wrap_word_idx(input logic [2:0] start_idx,
                                                 input logic [2:0] beat);
        return start_idx + beat;
    endfunction

endpackage

// File: rtl/il1_ahb_refill.sv
// IL1 miss refill engine: fetches one 8-word line with a critical-word-first
// AHB-Lite WRAP8 burst and streams every beat into the IL1 line buffer.
module il1_ahb_refill
    import il1_ahb_refill_pkg::*;
#(
    parameter int PC_LENGTH   = 32,
    parameter int INST_LENGTH = 32,
    parameter int LINE_WORDS  = IL1_LINE_WORDS
) (
    input  logic                          hclk,
    input  logic                          rst_n,
    input  logic                          refill_req,
    input  logic [PC_LENGTH-1:0]          refill_addr,
    output logic                          update,
    output logic [INST_LENGTH-1:0]        update_inst,
    output logic                          busy,
    output logic                          wr_en,
    output logic [$clog2(LINE_WORDS)-1:0] wr_word,
    output logic [INST_LENGTH-1:0]        wr_data,
    output logic                          line_done,
    output logic                          refill_err,
    output logic [PC_LENGTH-1:0]          haddr,
    output logic [1:0]                    htrans,
    output logic [2:0]                    hburst,
    output logic [2:0]                    hsize,
    output logic                          hwrite,
    input  logic                          hready,
    input  logic                          hresp,
    input  logic [INST_LENGTH-1:0]        hrdata
);

    if (LINE_WORDS != 8) begin : g_line_words_chk
        $error("il1_ahb_refill: LINE_WORDS must be 8 (WRAP8 burst)");
    end

    refill_state_t            state, state_nxt;
    logic [PC_LENGTH-1:2]     base_q, base_nxt;
    logic [3:0]               addr_cnt, addr_cnt_nxt;
    logic [2:0]               data_cnt, data_cnt_nxt;
    logic                     update_q, update_nxt;
    logic [INST_LENGTH-1:0]   inst_q, inst_nxt;
    htrans_t                  htrans_c;
    logic [PC_LENGTH-1:0]     haddr_c;
    logic                     wr_en_c, line_done_c, refill_err_c;
    logic                     unused_addr_lsbs;

    assign unused_addr_lsbs = ^refill_addr[1:0];

    always_ff @(posedge hclk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RF_IDLE;
            base_q   <= '0;
            addr_cnt <= '0;
            data_cnt <= '0;
            update_q <= 1'b0;
            inst_q   <= '0;
        end else begin
            state    <= state_nxt;
            base_q   <= base_nxt;
            addr_cnt <= addr_cnt_nxt;
            data_cnt <= data_cnt_nxt;
            update_q <= update_nxt;
            inst_q   <= inst_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        base_nxt     = base_q;
        addr_cnt_nxt = addr_cnt;
        data_cnt_nxt = data_cnt;
        update_nxt   = update_q;
        inst_nxt     = inst_q;
        htrans_c     = HTRANS_IDLE;
        haddr_c      = '0;
        wr_en_c      = 1'b0;
        line_done_c  = 1'b0;
        refill_err_c = 1'b0;

        case (state)
            RF_IDLE: begin
                if (refill_req) begin
                    base_nxt  = refill_addr[PC_LENGTH-1:2];
                    state_nxt = RF_ADDR;
                end
            end
            RF_ADDR: begin
                htrans_c = HTRANS_NONSEQ;
                haddr_c  = {base_q[PC_LENGTH-1:5], base_q[4:2], 2'b00};
                if (hready) begin
                    addr_cnt_nxt = 4'd1;
                    data_cnt_nxt = 3'd0;
                    state_nxt    = RF_STREAM;
                end
            end
            RF_STREAM: begin
                // Address phase of beat addr_cnt overlaps data phase of beat data_cnt.
                if (addr_cnt < 4'd8) begin
                    htrans_c = HTRANS_SEQ;
                end
                haddr_c = {base_q[PC_LENGTH-1:5],
                           wrap_word_idx(base_q[4:2], addr_cnt[2:0]), 2'b00};
                if (hresp == HRESP_ERROR) begin
                    // Leaving on the first ERROR cycle drops htrans to IDLE for the second.
                    refill_err_c = 1'b1;
                    update_nxt   = 1'b0;
                    state_nxt    = RF_IDLE;
                end else if (hready) begin
                    wr_en_c      = 1'b1;
                    data_cnt_nxt = data_cnt + 3'd1;
                    if (addr_cnt < 4'd8) begin
                        addr_cnt_nxt = addr_cnt + 4'd1;
                    end
                    if (data_cnt == 3'd0) begin
                        update_nxt = 1'b1;
                        inst_nxt   = hrdata;
                    end
                    if (data_cnt == 3'd7) begin
                        update_nxt = 1'b0;
                        state_nxt  = RF_DONE;
                    end
                end
            end
            RF_DONE: begin
                line_done_c = 1'b1;
                state_nxt   = RF_IDLE;
            end
            default: state_nxt = RF_IDLE;
        endcase
    end

    assign update      = update_q;
    assign update_inst = inst_q;
    assign busy        = (state != RF_IDLE);
    assign wr_en       = wr_en_c;
    assign wr_word     = wrap_word_idx(base_q[4:2], data_cnt);
    assign wr_data     = hrdata;
    assign line_done   = line_done_c;
    assign refill_err  = refill_err_c;
    assign haddr       = haddr_c;
    assign htrans      = htrans_c;
    assign hburst      = HBURST_WRAP8;
    assign hsize       = HSIZE_WORD;
    assign hwrite      = 1'b0;

endmodule
